// File: rtl/gshare_predictor.sv
// gshare_predictor -- global-history branch direction predictor.
//
// A table of 2^IDX_W saturating counters (CTR_W bits each) is indexed by the
// branch PC bits XORed with a global history register (GHR). After reset the
// table is swept one entry per cycle to weak-not-taken; requests and updates
// are ignored until the sweep completes and ready rises.
//
// Build option:
//   GSHARE_PREDICTOR_HASH_EN  defined   -> gshare: index = pred_pc ^ GHR
//                             undefined -> bimodal: index = pred_pc, no GHR
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pred_req/pred_pc  prediction request and PC index bits
//   pred_valid        registered, one cycle after an accepted request
//   pred_taken        predicted direction (counter MSB)
//   pred_index        hashed index used, to be returned with the update
//   ready             table initialised, requests accepted
//   upd_valid/upd_index/upd_taken   resolved-branch update
module gshare_predictor #(
    parameter int IDX_W  = 10,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req,
    input  logic [IDX_W-1:0] pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_index,
    output logic             ready,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;

    logic [CTR_W-1:0] table_mem [DEPTH];

    logic [HIST_W-1:0] ghr_reg;
    logic [IDX_W-1:0]  hash_index;
    logic [CTR_W-1:0]  upd_old;
    logic [CTR_W-1:0]  upd_ctr;
    logic [CTR_W-1:0]  pred_ctr;
    logic              run_upd;
    logic              accept;

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [CTR_W-1:0] wr_data;

    assign ready   = (state_reg == RUN);
    assign run_upd = (state_reg == RUN) && upd_valid;
    assign accept  = (state_reg == RUN) && pred_req;

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            INIT: begin
                ptr_next = ptr_reg + IDX_W'(1);
                if (ptr_reg == '1) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Global history
    // ------------------------------------------------------------------
`ifdef GSHARE_PREDICTOR_HASH_EN
    // Shift the outcome in at the LSB; the cast drops the old MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (run_upd) begin
            ghr_reg <= HIST_W'({ghr_reg, upd_taken});
        end
    end
`else
    // Bimodal build: history is a constant zero and folds out of the hash.
    assign ghr_reg = '0;
`endif

    // History is zero-extended, aligned to the index LSBs.
    assign hash_index = pred_pc ^ IDX_W'(ghr_reg);

    // ------------------------------------------------------------------
    // Counter update (saturating read-modify-write)
    // ------------------------------------------------------------------
    assign upd_old = table_mem[upd_index];

    always_comb begin
        upd_ctr = upd_old;
        if (upd_taken) begin
            if (upd_old != CTR_MAX) begin
                upd_ctr = upd_old + CTR_W'(1);
            end
        end else begin
            if (upd_old != '0) begin
                upd_ctr = upd_old - CTR_W'(1);
            end
        end
    end

    // Single write port shared by the init sweep and run-time updates.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ptr_reg;
        wr_data = CTR_WNT;
        if (!rst) begin
            if (state_reg == INIT) begin
                wr_en = 1'b1;
            end else if (upd_valid) begin
                wr_en   = 1'b1;
                wr_addr = upd_index;
                wr_data = upd_ctr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Prediction: forward the counter being written this cycle so a
    // same-cycle request to the same entry sees the post-update value.
    // ------------------------------------------------------------------
    always_comb begin
        pred_ctr = table_mem[hash_index];
        if (run_upd && (hash_index == upd_index)) begin
            pred_ctr = upd_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= accept;
            if (accept) begin
                pred_taken <= pred_ctr[CTR_W-1];
                pred_index <= hash_index;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor -- self-checking bench for gshare_predictor
// (IDX_W=4, CTR_W=2, HIST_W=3). A behavioural model tracks the init sweep,
// counters and history with plain integer arithmetic; table vectors and hand
// sequences cover the named corner cases, followed by random traffic.
module tb_gshare_predictor;

    localparam int IDX_W  = 4;
    localparam int CTR_W  = 2;
    localparam int HIST_W = 3;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int CMAX   = (1 << CTR_W) - 1;
    localparam int WNT    = (1 << (CTR_W - 1)) - 1;
    localparam int HALF   = 1 << (CTR_W - 1);
`ifdef GSHARE_PREDICTOR_HASH_EN
    localparam bit HASH_ON = 1'b1;
`else
    localparam bit HASH_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_req;
    logic [IDX_W-1:0] pred_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_index;
    logic             ready;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;

    gshare_predictor #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W),
        .HIST_W(HIST_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pred_req  (pred_req),
        .pred_pc   (pred_pc),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_index(pred_index),
        .ready     (ready),
        .upd_valid (upd_valid),
        .upd_index (upd_index),
        .upd_taken (upd_taken)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int txn       = 0;

    // Behavioural model state
    int m_tbl [DEPTH];
    int m_ghr   = 0;
    bit m_ready = 1'b0;
    int m_cnt   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (txn %0d)", name, act, exp, txn);
        end else begin
            pass_cnt++;
        end
    endfunction

    // PC that the hash maps onto the wanted index under the current history.
    function automatic logic [IDX_W-1:0] pc_for(input int idx);
        int h;
        h = HASH_ON ? m_ghr : 0;
        return IDX_W'(idx ^ h);
    endfunction

    // One clock cycle: drive, advance the model, clock, compare with model.
    task automatic step(input logic r, input logic rq, input logic [IDX_W-1:0] pc,
                        input logic uv, input logic [IDX_W-1:0] ui, input logic ut);
        bit e_valid;
        int e_idx;
        bit e_taken;
        int idx;
        rst       = r;
        pred_req  = rq;
        pred_pc   = pc;
        upd_valid = uv;
        upd_index = ui;
        upd_taken = ut;
        e_valid = 1'b0;
        e_idx   = 0;
        e_taken = 1'b0;
        if (r) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_ghr   = 0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_tbl[i]) m_tbl[i] = WNT;
            end
        end else begin
            idx = HASH_ON ? (int'(pc) ^ m_ghr) : int'(pc);
            if (uv) begin
                if (ut) m_tbl[ui] = (m_tbl[ui] < CMAX) ? m_tbl[ui] + 1 : CMAX;
                else    m_tbl[ui] = (m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0;
                if (HASH_ON) m_ghr = ((m_ghr * 2) + int'(ut)) % (1 << HIST_W);
            end
            if (rq) begin
                e_valid = 1'b1;
                e_idx   = idx;
                e_taken = (m_tbl[idx] >= HALF);
            end
        end
        @(posedge clk);
        #1;
        txn++;
        chk("ready", 32'(ready), 32'(m_ready));
        chk("pred_valid", 32'(pred_valid), 32'(e_valid));
        if (r) begin
            chk("rst_pred_index", 32'(pred_index), 32'd0);
            chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        end else if (e_valid) begin
            chk("pred_index", 32'(pred_index), 32'(e_idx));
            chk("pred_taken", 32'(pred_taken), 32'(e_taken));
        end
        $display("txn %0d rst=%0d req=%0d pc=%0h upd=%0d/%0h/%0d -> ready=%0d valid=%0d idx=%0h taken=%0d",
                 txn, r, rq, pc, uv, ui, ut, ready, pred_valid, pred_index, pred_taken);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    typedef struct {
        logic             req;
        logic [IDX_W-1:0] pc;
        logic             uv;
        logic [IDX_W-1:0] ui;
        logic             ut;
        logic             ev;
        logic [IDX_W-1:0] eidx;
        logic             et;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic rq, input int pc_on, input int pc_off,
                                input logic uv, input int ui, input logic ut,
                                input logic ev, input int eidx, input logic et);
        vec_t v;
        v.req  = rq;
        v.pc   = IDX_W'(HASH_ON ? pc_on : pc_off);
        v.uv   = uv;
        v.ui   = IDX_W'(ui);
        v.ut   = ut;
        v.ev   = ev;
        v.eidx = IDX_W'(eidx);
        v.et   = et;
        return v;
    endfunction

    initial begin
        // Counter walk on entry 5, then forwarding on entry 7 (history in comments, hash build).
        vecs[0] = mk(0, 0, 0, 1, 5, 1, 0, 0, 0);  // 01->10, ghr 1
        vecs[1] = mk(0, 0, 0, 1, 5, 1, 0, 0, 0);  // 10->11, ghr 3
        vecs[2] = mk(0, 0, 0, 1, 5, 1, 0, 0, 0);  // saturate 11, ghr 7
        vecs[3] = mk(1, 2, 5, 0, 0, 0, 1, 5, 1);  // read 5 -> taken
        vecs[4] = mk(0, 0, 0, 1, 5, 0, 0, 0, 0);  // 11->10, ghr 6
        vecs[5] = mk(0, 0, 0, 1, 5, 0, 0, 0, 0);  // 10->01, ghr 4
        vecs[6] = mk(1, 1, 5, 0, 0, 0, 1, 5, 0);  // read 5 -> not taken
        vecs[7] = mk(1, 3, 7, 1, 7, 1, 1, 7, 1);  // same-cycle update 7, forwarded 10
        vecs[8] = mk(1, 6, 7, 0, 0, 0, 1, 7, 1);  // ghr now 1, entry 7 holds 10
        vecs[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  // no request -> valid drops

        // Reset and initial sweep
        step(1'b1, 1'b1, '0, 1'b1, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, IDX_W'(i), 1'b1, IDX_W'(i), 1'b1);
            chk("init_ready", 32'(ready), 32'(i == DEPTH - 1));
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, pc_for(i), 1'b0, '0, 1'b0);
            chk("swept_taken", 32'(pred_taken), 32'd0);
        end

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            step(1'b0, vecs[i].req, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut);
            chk("vec_valid", 32'(pred_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk("vec_index", 32'(pred_index), 32'(vecs[i].eidx));
                chk("vec_taken", 32'(pred_taken), 32'(vecs[i].et));
            end
        end

        // Entry 3 to strongly-taken, then reset mid-RUN and again mid-INIT
        step(1'b0, 1'b0, '0, 1'b1, 4'd3, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 4'd3, 1'b1);
        step(1'b0, 1'b1, pc_for(3), 1'b0, '0, 1'b0);
        chk("e3_strong_taken", 32'(pred_taken), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) idle();
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            chk("resweep_ready", 32'(ready), 32'(i == DEPTH - 1));
        end
        step(1'b0, 1'b1, 4'd3, 1'b0, '0, 1'b0);
        chk("e3_after_resweep_idx", 32'(pred_index), 32'd3);
        chk("e3_after_resweep_taken", 32'(pred_taken), 32'd0);

`ifdef GSHARE_PREDICTOR_HASH_EN
        // GHR = 011, pc 0xA -> index 0x9, valid for exactly one cycle
        step(1'b0, 1'b0, '0, 1'b1, 4'd0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 4'd0, 1'b1);
        chk("pre_req_valid", 32'(pred_valid), 32'd0);
        step(1'b0, 1'b1, 4'hA, 1'b0, '0, 1'b0);
        chk("hash_valid", 32'(pred_valid), 32'd1);
        chk("hash_index", 32'(pred_index), 32'h9);
        idle();
        chk("hash_valid_drop", 32'(pred_valid), 32'd0);
`else
        // History must not affect the index in the bimodal build
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 4'd1, 1'b1);
        step(1'b0, 1'b1, 4'hA, 1'b0, '0, 1'b0);
        chk("bimodal_valid", 32'(pred_valid), 32'd1);
        chk("bimodal_index", 32'(pred_index), 32'hA);
        idle();
        chk("bimodal_valid_drop", 32'(pred_valid), 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 1)),
                 IDX_W'($urandom_range(0, DEPTH - 1)),
                 1'($urandom_range(0, 1)),
                 IDX_W'($urandom_range(0, DEPTH - 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
